// File: rtl/computer16_pkg.sv
// Shared definitions for the 16-bit computer slice units.
//   WIDTH_DEFAULT : default operand/result width
//   SLICE_W       : width of one shared logic slice
//   state_t       : sequencer states for multi-cycle slice units
//   id_t          : requester index carried with a response
package computer16_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int SLICE_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic id_t;

endpackage

// File: rtl/Or4.sv
// Or4: the 4-bit OR slice shared by the multi-cycle OR unit.
//   a, b : slice operands
//   out  : a | b
module Or4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] out
);

  assign out = a | b;

endmodule

// File: rtl/or16_slice_sched.sv
// or16_slice_sched: WIDTH-bit OR computed over NSLICE passes of one shared
// Or4 slice, low nibble first. Two requesters share the unit through
// round-robin arbitration; one response channel returns result and owner.
//   clk, rst               : clock, synchronous active-high reset
//   req0_* / req1_*        : valid/ready request channels with operands a, b
//   rsp_valid / rsp_ready  : response handshake
//   rsp_out, rsp_id        : a | b of the accepted pair and its requester
module or16_slice_sched
  import computer16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_id
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  id_t  last_grant, grant, id_q;
  logic grant_vld, accept, rsp_valid_q;

  // Operands and result held as slice-indexed packed arrays so the pass
  // counter selects a nibble directly.
  logic [NSLICE-1:0][SLICE-1:0] a_q, b_q, res_q;
  logic [SLICE-1:0] slice_out;

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win last time goes. last_grant resets to 1 so requester 0 wins
  // the first contended round.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b01:   begin grant = 1'b0;        grant_vld = 1'b1; end
      2'b10:   begin grant = 1'b1;        grant_vld = 1'b1; end
      2'b11:   begin grant = ~last_grant; grant_vld = 1'b1; end
      default: begin grant = last_grant;  grant_vld = 1'b0; end
    endcase
  end

  // Next state and handshake outputs. ready is only offered in IDLE, so a
  // requester arriving mid-operation simply waits with valid held.
  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant_vld && (grant == 1'b0) && !rst;
        req1_ready = grant_vld && (grant == 1'b1) && !rst;
        if (req0_ready || req1_ready) state_nx = RUN;
      end
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  Or4 u_or4 (
    .a   (a_q[cnt]),
    .b   (b_q[cnt]),
    .out (slice_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q        <= grant ? req1_a : req0_a;
          b_q        <= grant ? req1_b : req0_b;
          id_q       <= grant;
          last_grant <= grant;
          cnt        <= '0;
          res_q      <= '0;
        end
        RUN: begin
          res_q[cnt] <= slice_out;
          // Counter returns to 0 only alongside the move to DONE.
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = res_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_or16_slice_sched.sv
// Self-checking bench for or16_slice_sched: table of single transactions,
// hand sequences for arbitration/stall/reset corners, and random traffic,
// all checked every cycle against a transaction-level timing model.
module tb_or16_slice_sched;

  localparam int W      = 16;
  localparam int NSLICE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [W-1:0] rsp_out;

  always #5 clk = ~clk;

  or16_slice_sched #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_id(rsp_id)
  );

  int n_chk = 0, n_err = 0, cyc = 0;

  // Model: unit is either free, busy for a number of edges, or holding a response.
  int         m_busy = 0;
  bit         m_pend = 0, m_last = 1, m_id = 0, m_acc = 0, m_acc_id = 0;
  logic [W-1:0] m_out = '0;

  // DUT samples from the most recent step
  logic s_r0, s_r1, s_rv, s_rid;
  logic [W-1:0] s_rout;
  int   acc_cyc[$];
  bit   acc_id[$];
  logic [W-1:0] rsp_val[$];
  bit   rsp_idq[$];

  typedef struct {
    bit           id;
    logic [W-1:0] a, b, exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return {1'b1, ~last};
    if (v0)       return 2'b10;
    if (v1)       return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_last = 1; m_acc = 0;
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance
  // the model across the coming rising edge.
  task automatic step();
    logic [1:0] p;
    bit e_idle;
    @(negedge clk);
    p      = pick(req0_valid, req1_valid, m_last);
    e_idle = (m_busy == 0) && !m_pend;
    chk("req0_ready", 32'(req0_ready), 32'(!rst && e_idle && p[1] && !p[0]));
    chk("req1_ready", 32'(req1_ready), 32'(!rst && e_idle && p[1] && p[0]));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_pend));
    if (m_pend) begin
      chk("rsp_out", 32'(rsp_out), 32'(m_out));
      chk("rsp_id",  32'(rsp_id),  32'(m_id));
    end
    s_r0 = req0_ready; s_r1 = req1_ready; s_rv = rsp_valid;
    s_rout = rsp_out;  s_rid = rsp_id;
    if (req0_ready || req1_ready) begin
      acc_cyc.push_back(cyc); acc_id.push_back(req1_ready);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_val.push_back(rsp_out); rsp_idq.push_back(rsp_id);
    end
    m_acc = 0;
    if (rst) model_reset();
    else if (m_pend) begin
      if (rsp_ready) m_pend = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_pend = 1;
    end else if (p[1]) begin
      m_acc = 1; m_acc_id = p[0]; m_last = p[0]; m_id = p[0];
      m_out = p[0] ? (req1_a | req1_b) : (req0_a | req0_b);
      m_busy = NSLICE;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    @(posedge clk); #1;
    model_reset();
    step();
    rst = 0;
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    do begin step(); n++; end while (!m_acc && n < 20);
    if (!m_acc) chk({nm, " accept timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin step(); n++; end while (!s_rv && n < 20);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    rsp_ready = 1;
    if (v.id) begin req1_valid = 1; req1_a = v.a; req1_b = v.b; end
    else      begin req0_valid = 1; req0_a = v.a; req0_b = v.b; end
    wait_accept(nm);
    // Operands change right after accept; result must not follow them.
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'hFFFF; req0_b = 16'hFFFF; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    wait_rsp(n);
    chk({nm, " latency"}, 32'(n), 32'(NSLICE + 1));
    chk({nm, " out"},     32'(s_rout), 32'(v.exp));
    chk({nm, " id"},      32'(s_rid),  32'(v.id));
  endtask

  initial begin
    int n;
    logic [W-1:0] held_out;
    logic held_id;
    bit saw_rv;

    tbl[0] = '{0, 16'h1234, 16'h00F0, 16'h12F4};
    tbl[1] = '{0, 16'h0001, 16'h0002, 16'h0003};
    tbl[2] = '{1, 16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{1, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[4] = '{0, 16'hAAAA, 16'h5555, 16'hFFFF};
    tbl[5] = '{1, 16'h8001, 16'h0180, 16'h8181};
    tbl[6] = '{0, 16'h0F0F, 16'h0F00, 16'h0F0F};

    // Reset: ready held low under reset even with a valid request
    rst = 1; req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h00F0;
    @(posedge clk); #1; @(posedge clk); #1;
    model_reset();
    step();
    chk("reset rsp_out", 32'(s_rout), 32'(0));
    chk("reset rsp_id",  32'(s_rid),  32'(0));
    chk("reset ready0",  32'(s_r0),   32'(0));
    rst = 0; req0_valid = 0;
    step();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Both requesters valid from reset: strict alternation, 6-cycle spacing
    do_reset();
    acc_cyc.delete(); acc_id.delete(); rsp_val.delete(); rsp_idq.delete();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'hA000; req0_b = 16'h000A;
    req1_valid = 1; req1_a = 16'h0F00; req1_b = 16'h00F0;
    n = 0;
    while (acc_cyc.size() < 4 && n < 60) begin step(); n++; end
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (rsp_val.size() < 4 && n < 20) begin step(); n++; end
    chk("rr accepts", 32'(acc_cyc.size()), 32'(4));
    chk("rr responses", 32'(rsp_val.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) chk($sformatf("rr grant%0d", i), 32'(acc_id[i]), 32'(i % 2));
      if (i > 0 && i < acc_cyc.size())
        chk($sformatf("rr spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(6));
      if (i < rsp_val.size()) begin
        chk($sformatf("rr out%0d", i), 32'(rsp_val[i]), (i % 2) ? 32'h0FF0 : 32'hA00A);
        chk($sformatf("rr id%0d", i),  32'(rsp_idq[i]), 32'(i % 2));
      end
    end

    // Stall in DONE with a waiting requester
    do_reset();
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h00F0; rsp_ready = 0;
    wait_accept("stall");
    req0_valid = 0;
    wait_rsp(n);
    req1_valid = 1; req1_a = 16'h5555; req1_b = 16'h0A0A;
    held_out = s_rout; held_id = s_rid;
    chk("stall out", 32'(held_out), 32'h12F4);
    repeat (10) begin
      step();
      chk("stall hold out", 32'(s_rout), 32'(held_out));
      chk("stall hold id",  32'(s_rid),  32'(held_id));
      chk("stall ready1",   32'(s_r1),   32'(0));
    end
    rsp_ready = 1;
    step();
    chk("stall handshake", 32'(s_rv), 32'(1));
    chk("stall ready1 hs", 32'(s_r1), 32'(0));
    step();
    chk("ready1 after stall", 32'(s_r1), 32'(1));
    req1_valid = 0;
    wait_rsp(n);
    chk("post-stall out", 32'(s_rout), 32'h5F5F);
    chk("post-stall id",  32'(s_rid),  32'(1));

    // Reset in the second RUN cycle aborts the operation
    do_reset();
    rsp_ready = 1; req0_valid = 1; req0_a = 16'h00FF; req0_b = 16'hFF00;
    wait_accept("abort");
    req0_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    saw_rv = 0;
    repeat (8) begin
      step();
      saw_rv |= s_rv;
      chk("abort rsp_out", 32'(s_rout), 32'(0));
      chk("abort rsp_id",  32'(s_rid),  32'(0));
    end
    chk("abort no rsp", 32'(saw_rv), 32'(0));
    req1_valid = 1; req1_a = 16'h0300; req1_b = 16'h0030;
    step();
    chk("abort req1 accept", 32'(s_r1), 32'(1));
    req1_valid = 0;
    wait_rsp(n);
    chk("abort req1 out", 32'(s_rout), 32'h0330);
    req0_valid = 1; req1_valid = 1;
    step();
    chk("abort req0 wins", 32'(s_r0), 32'(1));
    req0_valid = 0; req1_valid = 0;
    wait_rsp(n);

    // Random traffic; requests held until the model says they were taken
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1; req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1; req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (m_acc) begin
        if (m_acc_id) begin req1_valid = 0; req1_a = 16'($urandom); end
        else          begin req0_valid = 0; req0_a = 16'($urandom); end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/or16_slice_sched.md
Name: or16_slice_sched

Overview:
- Multi-cycle 16-bit OR unit built from one shared 4-bit Or4 slice, sequenced over 4 cycles, low nibble first.
- Two requesters share the unit through round-robin arbitration with valid/ready handshakes; one response channel carries the result and the requester ID.
- Sits beside the ALU as a low-area logic unit and serves as the template for later shared-slice units.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, width of the shared Or4 slice; fixed at 4.
- NSLICE, WIDTH/SLICE (4), derived local constant: slice passes per operation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_out  out  WIDTH  a | b of the accepted pair.
- rsp_id  out  1  requester index that owns rsp_out.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (synchronous): state=IDLE, cnt=0, rsp_valid=0, rsp_out=0, rsp_id=0, last_grant=1 (requester 0 wins first). req*_ready=0 while rst=1.
- IDLE, arbitration:
  - grant = the only valid requester.
  - If both are valid: the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && !rst; combinational, at most one high.
- Accept edge (valid&&ready):
  - Latch a, b, id.
  - last_grant<=id, cnt<=0, result reg<=0, state<=RUN.
- RUN:
  - Or4 inputs a_q[cnt*4+:4], b_q[cnt*4+:4].
  - Each edge writes the Or4 output into result[cnt*4+:4] and increments cnt.
  - At cnt==NSLICE-1 the write completes and state<=DONE.
  - Exactly NSLICE RUN cycles.
- DONE:
  - rsp_valid=1; rsp_out and rsp_id stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, state<=IDLE.
- Latency: rsp_valid first high NSLICE+1 = 5 cycles after the accept edge. Minimum accept-to-accept spacing is 6 cycles with rsp_ready tied high.
- Boundary conditions:
  - Requester valid while RUN/DONE: ready stays 0. Request is held, not dropped. Requester must keep valid and data stable until ready.
  - Operand inputs changing after accept have no effect.
  - rsp_ready high outside DONE is ignored.
  - rsp_ready low in DONE stalls indefinitely. No new accept occurs.
  - Both requesters continuously valid: grants strictly alternate 0,1,0,1.
  - Reset during RUN or DONE: operation aborts, no response issued, last_grant returns to 1.
  - cnt wraps only via the state change; it never exceeds NSLICE-1.
  - All 16-bit values are legal; no overflow semantics (bitwise).

Decomposition:
- Shared package computer16_pkg:
  - WIDTH_DEFAULT=16 and SLICE_W=4 constants.
  - FSM state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Requester ID type (1 bit).
- One sub-module: the existing Or4 (ports a, b, out), instantiated once as the shared slice datapath.
- Arbiter, counter and FSM are inline; no separate arbiter module.

Test Plan:
- Reset, then req0 a=16'h1234 b=16'h00F0 -> req0_ready pulse one cycle. Then rsp_valid 5 cycles later with rsp_out=16'h12F4, rsp_id=0.
- req0 and req1 valid simultaneously from reset (req0 a=16'hA000 b=16'h000A; req1 a=16'h0F00 b=16'h00F0) -> first rsp_out=16'hA00A id=0, second rsp_out=16'h0FF0 id=1. req1_ready stays 0 until the first response completes.
- Both valid for 4 back-to-back operations with rsp_ready=1 -> ids 0,1,0,1; accept-to-accept exactly 6 cycles.
- rsp_ready held 0 for 10 cycles in DONE with req1 valid -> rsp_out and rsp_id unchanged; req1_ready stays 0. Releasing rsp_ready gives a one-cycle handshake, then req1 is accepted the next cycle.
- Assert rst during RUN cycle 2 -> rsp_valid never rises; all outputs 0. Next req1-only request is accepted; req0+req1 together then grants req0.
- Change req0_a to 16'hFFFF right after accept of a=16'h0001 b=16'h0002 -> rsp_out=16'h0003.
